// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: word-aligned imem requests, in-order prefetch FIFO, valid/ready to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise fetch_misaligned and stall issue.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction_code,
   output logic [31:0] pc_out,
   output logic        fetch_misaligned
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]    NOP     = 32'h0000_0013;

   typedef enum logic {BOOT, RUN} state_t;

   state_t           state, state_nxt;
   logic             run;
   logic [31:0]      fetch_pc, resp_pc;
   logic [31:0]      data_q [FIFO_DEPTH];
   logic [31:0]      pc_q   [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, inflight, discard_cnt;
   logic [CNT_W:0]   credit;
   logic [31:0]      target;
   logic             has_data, fire, push, pop, issue_block;

   // Handshakes: a transfer happens on a cycle where valid and ready are both
   // high at the rising clock edge; valid never depends on ready, and payload
   // holds stable while valid is high and ready is low.

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= BOOT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      run = 1'b0;
      case (state)
         RUN:     run = 1'b1;
         default: run = 1'b0;
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                misaligned <= 1'b0;
      else if (redirect_valid) misaligned <= |redirect_pc[1:0];
   end

   assign fetch_misaligned = misaligned;
   assign issue_block      = misaligned;
`else
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign fetch_misaligned    = 1'b0;
   assign issue_block         = 1'b0;
`endif

   assign target   = {redirect_pc[31:2], 2'b00};
   assign has_data = (count != '0);

   assign instr_valid      = has_data && !redirect_valid;
   assign instruction_code = has_data ? data_q[rd_ptr] : NOP;
   assign pc_out           = has_data ? pc_q[rd_ptr] : 32'h0;
   assign pop              = instr_valid && instr_ready;

   // A slot being popped this cycle counts as free so the buffer can stream one word per cycle.
   assign credit   = {1'b0, inflight} + {1'b0, count} - (CNT_W + 1)'(pop);
   assign imem_req = run && !halt && !redirect_valid && !issue_block && (credit < DEPTH_C);
   assign imem_addr = fetch_pc;
   assign fire      = imem_req && imem_ready;

   assign push = imem_rvalid && !redirect_valid && (discard_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         inflight    <= '0;
         discard_cnt <= '0;
      end else begin
         inflight <= inflight + CNT_W'(fire) - CNT_W'(imem_rvalid);
         if (redirect_valid) begin
            // Every response still owed by memory belongs to the old stream.
            fetch_pc    <= target;
            resp_pc     <= target;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            discard_cnt <= inflight - CNT_W'(imem_rvalid);
         end else begin
            if (fire) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
               wr_ptr  <= wr_ptr + PTR_W'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (imem_rvalid && (discard_cnt != '0)) discard_cnt <= discard_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= imem_rdata;
         pc_q[wr_ptr]   <= resp_pc;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && ({1'b0, count} == DEPTH_C)));
   a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
      !(imem_rvalid && (inflight == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with programmable latency,
// immediate-assertion checks on each cycle of interest, one summary line at the end.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        halt = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instruction_code;
   logic [31:0] pc_out;
   logic        fetch_misaligned;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] exp_q[$];
   logic [31:0] e;

   instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .halt             (halt),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instruction_code (instruction_code),
      .pc_out           (pc_out),
      .fetch_misaligned (fetch_misaligned)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0013;
   endfunction

   // In-order instruction memory: request seen at negedge, answered mem_lat cycles later.
   always begin
      @(negedge clk);
      if (!rst) begin
         mq_addr.delete();
         mq_due.delete();
      end else if (imem_req && imem_ready) begin
         mq_addr.push_back(imem_addr);
         mq_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (rst && mq_due.size() != 0 && mq_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
   end

   // driver tasks: inputs change just after posedge, outputs sampled at negedge
   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Holds reset for two cycles, then releases it; returns in the BOOT cycle.
   task automatic reset_dut(input int lat);
      go();
      rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1; mem_lat = lat;
      look();
      chkb("mreset_valid", instr_valid, 1'b0);
      chkb("mreset_req", imem_req, 1'b0);
      go(); look();
      go(); rst = 1'b1; look();
      chkb("boot_req", imem_req, 1'b0);
   endtask

   initial begin
      // ---- reset values
      go(); look();
      chkb("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chkb("rst_valid", instr_valid, 1'b0);
      chk("rst_code", instruction_code, 32'h0000_0013);
      chk("rst_pc", pc_out, 32'h0);
      chkb("rst_mis", fetch_misaligned, 1'b0);

      // ---- boot and streaming, latency 1
      go(); rst = 1'b1; look();
      chkb("boot_req", imem_req, 1'b0);
      go(); look();
      chkb("c1_req", imem_req, 1'b1);
      chk("c1_addr", imem_addr, 32'h0);
      chkb("c1_valid", instr_valid, 1'b0);
      go(); look();
      chk("c2_addr", imem_addr, 32'h4);
      chkb("c2_valid", instr_valid, 1'b0);
      exp_q = {32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 3; i++) begin
         go(); look();
         e = exp_q.pop_front();
         chkb("stream_valid", instr_valid, 1'b1);
         chk("stream_pc", pc_out, e);
         chk("stream_code", instruction_code, mem_word(e));
      end

      // ---- decode stall for five cycles: two words buffered, head stable
      for (int i = 0; i < 5; i++) begin
         go(); instr_ready = 1'b0; look();
         chkb("stall_req", imem_req, 1'b0);
         chkb("stall_valid", instr_valid, 1'b1);
         chk("stall_pc", pc_out, 32'hC);
         chk("stall_code", instruction_code, mem_word(32'hC));
      end
      exp_q = {32'hC, 32'h10, 32'h14};
      for (int i = 0; i < 3; i++) begin
         go(); instr_ready = 1'b1; look();
         e = exp_q.pop_front();
         chkb("resume_valid", instr_valid, 1'b1);
         chk("resume_pc", pc_out, e);
         chk("resume_code", instruction_code, mem_word(e));
         if (i == 0) chk("resume_addr", imem_addr, 32'h14);
      end

      // ---- latency 3: redirect with two fetches in flight
      reset_dut(3);
      go(); look();
      chk("l3_c1_addr", imem_addr, 32'h0);
      go(); look();
      chk("l3_c2_addr", imem_addr, 32'h4);
      go(); redirect_valid = 1'b1; redirect_pc = 32'h100; look();
      chkb("l3_redir_req", imem_req, 1'b0);
      chkb("l3_redir_valid", instr_valid, 1'b0);
      go(); redirect_valid = 1'b0; look();
      chkb("l3_c4_valid", instr_valid, 1'b0);
      go(); look();
      chkb("l3_c5_req", imem_req, 1'b1);
      chk("l3_c5_addr", imem_addr, 32'h100);
      for (int i = 0; i < 3; i++) begin
         go(); look();
         chkb("l3_stale_valid", instr_valid, 1'b0);
      end
      go(); look();
      chkb("l3_new_valid", instr_valid, 1'b1);
      chk("l3_new_pc", pc_out, 32'h100);
      chk("l3_new_code", instruction_code, mem_word(32'h100));
      go(); look();
      chk("l3_next_pc", pc_out, 32'h104);
      go(); look();
      go(); look();

      // ---- redirect coinciding with a response and a ready decode
      go(); redirect_valid = 1'b1; redirect_pc = 32'h100; look();
      chkb("rr_valid", instr_valid, 1'b0);
      chkb("rr_req", imem_req, 1'b0);
      go(); redirect_valid = 1'b0; look();
      chkb("rr_next_req", imem_req, 1'b1);
      chk("rr_next_addr", imem_addr, 32'h100);
      chkb("rr_next_valid", instr_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         go(); look();
         chkb("rr_wait_valid", instr_valid, 1'b0);
      end
      go(); look();
      chkb("rr_out_valid", instr_valid, 1'b1);
      chk("rr_out_pc", pc_out, 32'h100);
      chk("rr_out_code", instruction_code, mem_word(32'h100));

      // ---- halt with one fetch in flight
      reset_dut(1);
      go(); look();
      chk("h_c1_addr", imem_addr, 32'h0);
      go(); halt = 1'b1; look();
      chkb("h_c2_req", imem_req, 1'b0);
      go(); look();
      chkb("h_land_valid", instr_valid, 1'b1);
      chk("h_land_pc", pc_out, 32'h0);
      chk("h_land_code", instruction_code, mem_word(32'h0));
      chkb("h_c3_req", imem_req, 1'b0);
      go(); look();
      chkb("h_c4_req", imem_req, 1'b0);
      chkb("h_c4_valid", instr_valid, 1'b0);
      go(); halt = 1'b0; look();
      chkb("h_resume_req", imem_req, 1'b1);
      chk("h_resume_addr", imem_addr, 32'h4);
      go(); look();
      go(); look();
      chk("h_next_pc", pc_out, 32'h4);

      // ---- misaligned redirect target
      go(); redirect_valid = 1'b1; redirect_pc = 32'h102; look();
      chkb("mis_redir_valid", instr_valid, 1'b0);
      go(); redirect_valid = 1'b0; look();
`ifdef FETCH_MISALIGN_TRAP_EN
      chkb("mis_flag", fetch_misaligned, 1'b1);
      chkb("mis_req", imem_req, 1'b0);
      go(); look();
      chkb("mis_hold_flag", fetch_misaligned, 1'b1);
      chkb("mis_hold_req", imem_req, 1'b0);
      go(); redirect_valid = 1'b1; redirect_pc = 32'h200; look();
      go(); redirect_valid = 1'b0; look();
      chkb("mis_clear_flag", fetch_misaligned, 1'b0);
      chkb("mis_clear_req", imem_req, 1'b1);
      chk("mis_clear_addr", imem_addr, 32'h200);
`else
      chkb("mis_flag", fetch_misaligned, 1'b0);
      chkb("mis_req", imem_req, 1'b1);
      chk("mis_addr", imem_addr, 32'h100);
      go(); look();
      go(); look();
      chkb("mis_out_valid", instr_valid, 1'b1);
      chk("mis_out_pc", pc_out, 32'h100);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
